// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants, decoder state encoding and frame check helper for the PS/2 key tracker.
package ps2_key_tracker_pkg;

    localparam logic [7:0]  PS2_BRK    = 8'hF0;
    localparam logic [7:0]  PS2_EXT    = 8'hE0;
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // head = {parity, data[7:0], start}; true when start/stop/odd parity are all correct
    function automatic logic frame_ok(input logic [9:0] head, input logic stop);
        return ~head[0] & stop & (^head[9:1]);
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Raw PS/2 lines in, decoded key status out.
interface ps2_key_tracker_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LVL_W = 4
);
    logic             ps2_clk;
    logic             ps2_data;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_held;
    logic [CNT_W-1:0] press_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output ps2_clk, ps2_data,
        input  key_code, key_ext, key_held, press_cnt, err_cnt, overflow, fifo_level
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output key_code, key_ext, key_held, press_cnt, err_cnt, overflow, fifo_level
    );
endinterface

// File: rtl/ps2_key_tracker_frame_rx.sv
// PS/2 frame receiver: synchronise, detect clock falls, shift 11 bits, check frame, time out.
module ps2_key_tracker_frame_rx
    import ps2_key_tracker_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BCNT_W = 4;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall_c;
    logic                   dat_c;
    logic                   last_c;
    logic                   good_c;
    logic [9:0]             sh_q;
    logic [BCNT_W-1:0]      bitcnt_q;
    logic [TMO_W-1:0]       tmo_q;
    logic                   byte_valid_q;
    logic                   frame_err_q;
    logic [7:0]             byte_q;

    // Synchronisers reset to the idle-high bus level so reset release causes no false fall
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall_c = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign dat_c  = dat_sync_q[SYNC_STAGES-1];
    assign last_c = (bitcnt_q == BCNT_W'(FRAME_BITS - 1));
    assign good_c = frame_ok(sh_q, dat_c);

    // Bit capture, frame check on the stop bit, and partial-frame timeout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sh_q         <= '0;
            bitcnt_q     <= '0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            byte_q       <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (fall_c) begin
                tmo_q <= '0;
                if (last_c) begin
                    bitcnt_q     <= '0;
                    byte_q       <= sh_q[8:1];
                    byte_valid_q <= good_c;
                    frame_err_q  <= ~good_c;
                end else begin
                    sh_q     <= {dat_c, sh_q[9:1]};
                    bitcnt_q <= bitcnt_q + BCNT_W'(1);
                end
            end else if (bitcnt_q != '0) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    bitcnt_q <= '0;
                    tmo_q    <= '0;
                end else begin
                    tmo_q <= tmo_q + TMO_W'(1);
                end
            end
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: frame receiver, byte FIFO, make/break/extended decoder, counters.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             resetn,
    ps2_key_tracker_if.slave bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             rx_err;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             full_c;
    logic             pop_c;
    logic             wr_c;
    logic [7:0]       pop_byte_c;
    logic             ovf_q;

    dec_state_e       state_q;
    logic [7:0]       key_code_q;
    logic             key_ext_q;
    logic             key_held_q;
    logic [CNT_W-1:0] press_q;
    logic [CNT_W-1:0] err_q;
    logic             mk_c;
    logic             bk_c;
    logic             ext_c;
    logic             match_c;

    ps2_key_tracker_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk          (clk),
        .resetn       (resetn),
        .ps2_clk_i    (bus.ps2_clk),
        .ps2_data_i   (bus.ps2_data),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_err)
    );

    // Decoder is always ready, so the FIFO drains one byte per cycle whenever non-empty
    assign pop_c      = (level_q != '0);
    assign full_c     = (level_q == LW'(FIFO_DEPTH));
    assign wr_c       = rx_valid & (~full_c | pop_c);
    assign pop_byte_c = mem_q[rd_ptr_q];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_c && !pop_c) begin
                level_q <= level_q + LW'(1);
            end else if (!wr_c && pop_c) begin
                level_q <= level_q - LW'(1);
            end
            if (rx_valid && full_c && !pop_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Frame error counter, saturating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= '0;
        end else if (rx_err && (err_q != '1)) begin
            err_q <= err_q + CNT_W'(1);
        end
    end

    // Classify the popped byte as a make or break event given the prefix state
    always_comb begin
        mk_c  = 1'b0;
        bk_c  = 1'b0;
        ext_c = 1'b0;
        if (pop_c) begin
            case (state_q)
                ST_IDLE:    mk_c = (pop_byte_c != PS2_EXT) && (pop_byte_c != PS2_BRK);
                ST_EXT: begin
                    mk_c  = (pop_byte_c != PS2_BRK);
                    ext_c = 1'b1;
                end
                ST_BRK:     bk_c = 1'b1;
                ST_EXT_BRK: begin
                    bk_c  = 1'b1;
                    ext_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign match_c = (key_code_q == pop_byte_c) && (key_ext_q == ext_c);

    // Decoder FSM with key status and press counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            key_code_q <= '0;
            key_ext_q  <= 1'b0;
            key_held_q <= 1'b0;
            press_q    <= '0;
        end else begin
            if (pop_c) begin
                case (state_q)
                    ST_IDLE: begin
                        if (pop_byte_c == PS2_EXT) begin
                            state_q <= ST_EXT;
                        end else if (pop_byte_c == PS2_BRK) begin
                            state_q <= ST_BRK;
                        end
                    end
                    ST_EXT:  state_q <= (pop_byte_c == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
            // Typematic repeat of the held key leaves everything unchanged
            if (mk_c && !(key_held_q && match_c)) begin
                key_code_q <= pop_byte_c;
                key_ext_q  <= ext_c;
                key_held_q <= 1'b1;
                press_q    <= press_q + CNT_W'(1);
            end
            // Release only clears held for the displayed key; key_code is retained
            if (bk_c && match_c) begin
                key_held_q <= 1'b0;
            end
        end
    end

    assign bus.key_code   = key_code_q;
    assign bus.key_ext    = key_ext_q;
    assign bus.key_held   = key_held_q;
    assign bus.press_cnt  = press_q;
    assign bus.err_cnt    = err_q;
    assign bus.overflow   = ovf_q;
    assign bus.fifo_level = level_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus randomized traffic vs a key-event model.
module tb_ps2_key_tracker;

    localparam int unsigned SYNC_STAGES = 3;
    localparam int unsigned FIFO_DEPTH  = 8;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = -1;
    bit settled = 1'b0;
    bit stall   = 1'b0;

    // Behavioural model: key status plus pending-prefix flags
    logic [7:0]       m_code;
    logic             m_ext, m_held, m_ovf, m_pe0, m_pf0;
    logic [CNT_W-1:0] m_press, m_err;
    logic [7:0]       stall_q [$];

    logic [7:0] pool [10] = '{8'h1C, 8'h1C, 8'h75, 8'h2A, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h12, 8'h59};
    logic [7:0] sb   [9]  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};

    always #5 clk = ~clk;

    ps2_key_tracker_if #(.CNT_W(CNT_W), .LVL_W(LVL_W)) bus ();

    ps2_key_tracker #(
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_code"},  32'(bus.key_code),   32'(m_code));
        chk({tag, "_ext"},   32'(bus.key_ext),    32'(m_ext));
        chk({tag, "_held"},  32'(bus.key_held),   32'(m_held));
        chk({tag, "_press"}, 32'(bus.press_cnt),  32'(m_press));
        chk({tag, "_err"},   32'(bus.err_cnt),    32'(m_err));
        chk({tag, "_ovf"},   32'(bus.overflow),   32'(m_ovf));
        chk({tag, "_level"}, 32'(bus.fifo_level), 32'(0));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_code"},  32'(bus.key_code),   32'(0));
        chk({tag, "_ext"},   32'(bus.key_ext),    32'(0));
        chk({tag, "_held"},  32'(bus.key_held),   32'(0));
        chk({tag, "_press"}, 32'(bus.press_cnt),  32'(0));
        chk({tag, "_err"},   32'(bus.err_cnt),    32'(0));
        chk({tag, "_ovf"},   32'(bus.overflow),   32'(0));
        chk({tag, "_level"}, 32'(bus.fifo_level), 32'(0));
    endtask

    task automatic model_clear();
        m_code = '0; m_ext = 1'b0; m_held = 1'b0; m_ovf = 1'b0;
        m_pe0 = 1'b0; m_pf0 = 1'b0; m_press = '0; m_err = '0;
        stall_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_pf0) begin
            if (m_code == b && m_ext == m_pe0) m_held = 1'b0;
            m_pf0 = 1'b0;
            m_pe0 = 1'b0;
        end else if (b == 8'hF0) begin
            m_pf0 = 1'b1;
        end else if (b == 8'hE0 && !m_pe0) begin
            m_pe0 = 1'b1;
        end else begin
            if (!(m_held && m_code == b && m_ext == m_pe0)) begin
                m_code  = b;
                m_ext   = m_pe0;
                m_held  = 1'b1;
                m_press = m_press + CNT_W'(1);
            end
            m_pe0 = 1'b0;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = (~^b) ^ bad_par;
        f[10]   = ~bad_stop;
        return f;
    endfunction

    // Drive nbits of a frame; on the stop bit, measure clk edges from the fall to the first output change
    task automatic send_raw(input logic [10:0] f, input int nbits);
        int h;
        logic [7:0] c0;
        logic h0, e0;
        logic [CNT_W-1:0] p0;
        for (int i = 0; i < nbits; i++) begin
            h = int'($urandom_range(8, 3));
            bus.ps2_data = f[i];
            repeat (h) @(posedge clk);
            #1;
            if (i == 10) begin
                settled = 1'b0;
                c0 = bus.key_code; h0 = bus.key_held; e0 = bus.key_ext; p0 = bus.press_cnt;
                lat = -1;
            end
            bus.ps2_clk = 1'b0;
            if (i == 10) begin
                for (int n = 1; n <= 12; n++) begin
                    @(posedge clk);
                    #1;
                    if (lat < 0 && (bus.key_code !== c0 || bus.key_held !== h0 ||
                                    bus.key_ext !== e0 || bus.press_cnt !== p0))
                        lat = n;
                end
            end else begin
                repeat (h) @(posedge clk);
                #1;
            end
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
        send_raw(mk_frame(b, bad_par, bad_stop), 11);
        if (bad_par || bad_stop) begin
            if (m_err != '1) m_err = m_err + CNT_W'(1);
        end else if (stall) begin
            if (stall_q.size() < FIFO_DEPTH) stall_q.push_back(b);
            else m_ovf = 1'b1;
        end else begin
            model_byte(b);
        end
        settled = !stall;
    endtask

    task automatic do_reset(input string tag);
        settled = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(tag);
        model_clear();
        resetn = 1'b1;
        @(posedge clk);
        #1;
        settled = 1'b1;
    endtask

    // Continuous comparison against the model whenever no frame is in flight
    always @(negedge clk) begin
        if (settled && resetn && !stall) chk_all("cyc");
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        model_clear();
        do_reset("rst0");

        // Make then break of one key, plus fall-to-output latency
        send_byte(8'h1C);
        chk("t1_latency", 32'(lat), 32'(SYNC_STAGES + 3));
        chk("t1_code", 32'(bus.key_code), 32'(8'h1C));
        chk("t1_held_make", 32'(bus.key_held), 32'(1));
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("t1_held_brk", 32'(bus.key_held), 32'(0));
        chk("t1_code_kept", 32'(bus.key_code), 32'(8'h1C));
        chk("t1_press", 32'(bus.press_cnt), 32'(1));

        // Typematic repeats do not count
        do_reset("rst2");
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        chk("t2_press", 32'(bus.press_cnt), 32'(1));
        chk("t2_held", 32'(bus.key_held), 32'(0));

        // Extended make / break
        do_reset("rst3");
        send_byte(8'hE0); send_byte(8'h75);
        chk("t3_held_make", 32'(bus.key_held), 32'(1));
        chk("t3_ext", 32'(bus.key_ext), 32'(1));
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        chk("t3_code", 32'(bus.key_code), 32'(8'h75));
        chk("t3_ext_kept", 32'(bus.key_ext), 32'(1));
        chk("t3_held_brk", 32'(bus.key_held), 32'(0));
        chk("t3_press", 32'(bus.press_cnt), 32'(1));

        // Bad parity, good byte, bad stop
        do_reset("rst4");
        send_byte(8'h33, 1'b1, 1'b0);
        send_byte(8'h1C);
        chk("t4_err1", 32'(bus.err_cnt), 32'(1));
        chk("t4_code", 32'(bus.key_code), 32'(8'h1C));
        send_byte(8'h44, 1'b0, 1'b1);
        chk("t4_err2", 32'(bus.err_cnt), 32'(2));

        // Partial frame timeout
        do_reset("rst5");
        send_raw(mk_frame(8'h7E, 1'b0, 1'b0), 5);
        repeat (TIMEOUT_CYC + 10) @(posedge clk);
        #1;
        send_byte(8'h2A);
        chk("t5_code", 32'(bus.key_code), 32'(8'h2A));
        chk("t5_err", 32'(bus.err_cnt), 32'(0));
        chk("t5_press", 32'(bus.press_cnt), 32'(1));

        // Randomized traffic
        do_reset("rstr");
        for (int k = 0; k < 150; k++) begin
            int r;
            r = int'($urandom_range(9, 0));
            send_byte(pool[r], ($urandom_range(4, 0) == 0), ($urandom_range(9, 0) == 0));
        end

        // Error counter saturation
        for (int k = 0; k < 16; k++) send_byte(8'h55, 1'b1, 1'b0);
        chk("sat_err", 32'(bus.err_cnt), 32'({CNT_W{1'b1}}));

        // FIFO overflow with the decoder stalled, then in-order drain
        do_reset("rst6");
        force dut.pop_c = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 9; i++) send_byte(sb[i]);
        chk("t6_level_full", 32'(bus.fifo_level), 32'(FIFO_DEPTH));
        chk("t6_ovf", 32'(bus.overflow), 32'(1));
        chk("t6_code_stalled", 32'(bus.key_code), 32'(0));
        release dut.pop_c;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("t6_order", 32'(bus.key_code), 32'(sb[i]));
            chk("t6_level", 32'(bus.fifo_level), 32'(FIFO_DEPTH - 1 - i));
        end
        stall = 1'b0;
        foreach (stall_q[i]) model_byte(stall_q[i]);
        settled = 1'b1;
        chk("t6_press", 32'(bus.press_cnt), 32'(8));
        chk("t6_ovf_sticky", 32'(bus.overflow), 32'(1));

        // Reset in the middle of a frame
        send_raw(mk_frame(8'h2A, 1'b0, 1'b0), 5);
        settled = 1'b0;
        resetn = 1'b0;
        #1;
        chk_zero("t6_rst");
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        settled = 1'b1;
        send_byte(8'h1C);
        chk("t6_post_code", 32'(bus.key_code), 32'(8'h1C));
        chk("t6_post_press", 32'(bus.press_cnt), 32'(1));
        chk("t6_post_ovf", 32'(bus.overflow), 32'(0));

        settled = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
